// File: rtl/dm_store_buffer_if.sv
// Bus bundle between the MEM stage / data memory and the posted-write store buffer.
// The slave side is the buffer; the master side is the pipeline and memory environment.
interface dm_store_buffer_if #(
    parameter int DEPTH = 4
);
    logic                     St_Valid_In;
    logic [31:0]              St_Addr_In;
    logic [31:0]              St_Data_In;
    logic [31:0]              St_Pc_In;
    logic                     Ld_Valid_In;
    logic [31:0]              Ld_Addr_In;
    logic [31:0]              Dm_Data_In;
    logic [31:0]              Ld_Data_Out;
    logic                     Stall_Out;
    logic                     Dm_We_Out;
    logic [31:0]              Dm_Addr_Out;
    logic [31:0]              Dm_Data_Out;
    logic [31:0]              Dm_Pc_Out;
    logic [$clog2(DEPTH):0]   Count_Out;

    modport master (
        output St_Valid_In, St_Addr_In, St_Data_In, St_Pc_In,
        output Ld_Valid_In, Ld_Addr_In, Dm_Data_In,
        input  Ld_Data_Out, Stall_Out, Dm_We_Out, Dm_Addr_Out,
        input  Dm_Data_Out, Dm_Pc_Out, Count_Out
    );

    modport slave (
        input  St_Valid_In, St_Addr_In, St_Data_In, St_Pc_In,
        input  Ld_Valid_In, Ld_Addr_In, Dm_Data_In,
        output Ld_Data_Out, Stall_Out, Dm_We_Out, Dm_Addr_Out,
        output Dm_Data_Out, Dm_Pc_Out, Count_Out
    );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: queues MEM-stage stores and retires them when the memory port is idle.
// Define SB_FORWARD_EN to serve loads from buffered stores instead of stalling them until empty.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset_n,
    dm_store_buffer_if.slave    Bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, push, drain, stallSt, stallLd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign stallSt = Bus.St_Valid_In & full;
    assign push    = Reset_n & Bus.St_Valid_In & ~full;
    // The memory port is only borrowed when the MEM stage leaves it idle or is stalled anyway.
    assign drain   = Reset_n & ~empty &
                     ((~Bus.St_Valid_In & ~Bus.Ld_Valid_In) | stallSt | stallLd);

`ifdef SB_FORWARD_EN
    logic [31:0] fwdData;
    logic [AW-1:0] idx;

    assign stallLd = 1'b0;

    // Walk oldest to youngest so the last hit, the youngest store, wins.
    always_comb begin
        fwdData = Bus.Dm_Data_In;
        idx     = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if ((CW'(i) < count_q) && (addr_q[idx] == Bus.Ld_Addr_In)) begin
                fwdData = data_q[idx];
            end
        end
    end

    assign Bus.Ld_Data_Out = fwdData;
`else
    assign stallLd         = Bus.Ld_Valid_In & ~empty;
    assign Bus.Ld_Data_Out = Bus.Dm_Data_In;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            tail_d  = tail_q + AW'(1);
            count_d = count_q + CW'(1);
        end
        if (drain) begin
            head_d  = head_q + AW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            addr_q[tail_q] <= Bus.St_Addr_In;
            data_q[tail_q] <= Bus.St_Data_In;
            pc_q[tail_q]   <= Bus.St_Pc_In;
        end
    end

    assign Bus.Dm_We_Out   = drain;
    assign Bus.Dm_Addr_Out = drain ? addr_q[head_q] : Bus.Ld_Addr_In;
    assign Bus.Dm_Data_Out = drain ? data_q[head_q] : 32'h0;
    assign Bus.Dm_Pc_Out   = drain ? pc_q[head_q]   : 32'h0;
    assign Bus.Stall_Out   = Reset_n & (stallSt | stallLd);
    assign Bus.Count_Out   = count_q;
endmodule
